// File: rtl/ddr_app_arbiter.sv
// Two-port arbiter/sequencer in front of the MIG user app interface.
// Single-beat commands, round-robin with burst limit, in-order read tag FIFO.
module ddr_app_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 30,
  parameter int unsigned DATA_WIDTH     = 512,
  parameter int unsigned MASK_WIDTH     = 64,
  parameter int unsigned RD_OUTSTANDING = 16,
  parameter int unsigned MAX_BURST      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init_calib_complete,
  input  logic                  p0_cmd_valid,
  output logic                  p0_cmd_ready,
  input  logic                  p0_cmd_we,
  input  logic [ADDR_WIDTH-1:0] p0_cmd_addr,
  input  logic [DATA_WIDTH-1:0] p0_cmd_wdata,
  input  logic [MASK_WIDTH-1:0] p0_cmd_wmask,
  output logic                  p0_rd_valid,
  input  logic                  p1_cmd_valid,
  output logic                  p1_cmd_ready,
  input  logic                  p1_cmd_we,
  input  logic [ADDR_WIDTH-1:0] p1_cmd_addr,
  input  logic [DATA_WIDTH-1:0] p1_cmd_wdata,
  input  logic [MASK_WIDTH-1:0] p1_cmd_wmask,
  output logic                  p1_rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0] app_addr,
  output logic [2:0]            app_cmd,
  output logic                  app_en,
  input  logic                  app_rdy,
  output logic [DATA_WIDTH-1:0] app_wdf_data,
  output logic [MASK_WIDTH-1:0] app_wdf_mask,
  output logic                  app_wdf_wren,
  output logic                  app_wdf_end,
  input  logic                  app_wdf_rdy,
  input  logic [DATA_WIDTH-1:0] app_rd_data,
  input  logic                  app_rd_data_valid,
  input  logic                  app_rd_data_end,
  output logic                  err_unexp_rd
);

  localparam int unsigned PTR_W   = (RD_OUTSTANDING > 1) ? $clog2(RD_OUTSTANDING) : 1;
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);
  localparam logic [2:0]  CMD_WRITE = 3'b000;
  localparam logic [2:0]  CMD_READ  = 3'b001;

  typedef enum logic {IDLE, ISSUE} state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  we;
    logic [DATA_WIDTH-1:0] wdata;
    logic [MASK_WIDTH-1:0] wmask;
  } cmd_t;

  state_t state, state_nxt;

  logic [RD_OUTSTANDING-1:0] fifo_mem;
  logic [PTR_W-1:0]          wr_ptr, rd_ptr;
  logic [CNT_W-1:0]          fifo_cnt;
  logic                      fifo_full, fifo_empty, fifo_head;
  logic                      push_c, pop_c;

  logic                      rr_ptr;
  logic [BURST_W-1:0]        burst_cnt;
  logic                      burst_max;

  logic                      elig0, elig1, grant_c, gport_c;
  logic                      cmd_done_c, wdf_done_c;
  cmd_t                      cmd0, cmd1, sel_cmd;

  assign fifo_full  = (fifo_cnt == CNT_W'(RD_OUTSTANDING));
  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_head  = fifo_mem[rd_ptr];
  assign burst_max  = (burst_cnt >= BURST_W'(MAX_BURST));

  assign cmd0 = '{addr: p0_cmd_addr, we: p0_cmd_we, wdata: p0_cmd_wdata, wmask: p0_cmd_wmask};
  assign cmd1 = '{addr: p1_cmd_addr, we: p1_cmd_we, wdata: p1_cmd_wdata, wmask: p1_cmd_wmask};

  // Full is only judged here in IDLE, so every granted read has a tag slot waiting.
  assign elig0 = !rst && (state == IDLE) && init_calib_complete && p0_cmd_valid &&
                 (p0_cmd_we || !fifo_full);
  assign elig1 = !rst && (state == IDLE) && init_calib_complete && p1_cmd_valid &&
                 (p1_cmd_we || !fifo_full);

  // Pointer port wins a contention unless it has used up its burst allowance.
  always_comb begin
    grant_c = 1'b0;
    gport_c = 1'b0;
    if (elig0 && elig1) begin
      grant_c = 1'b1;
      gport_c = burst_max ? !rr_ptr : rr_ptr;
    end else if (elig0) begin
      grant_c = 1'b1;
    end else if (elig1) begin
      grant_c = 1'b1;
      gport_c = 1'b1;
    end
  end

  assign sel_cmd      = gport_c ? cmd1 : cmd0;
  assign p0_cmd_ready = grant_c && !gport_c;
  assign p1_cmd_ready = grant_c && gport_c;

  // A strobe that is low (or being accepted now) counts as done.
  assign cmd_done_c = !app_en || app_rdy;
  assign wdf_done_c = !app_wdf_wren || app_wdf_rdy;

  assign push_c = app_en && app_rdy && (app_cmd == CMD_READ);
  assign pop_c  = app_rd_data_valid && app_rd_data_end && !fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_c) state_nxt = ISSUE;
      ISSUE:   if (cmd_done_c && wdf_done_c) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Command latch, app strobes and arbitration history.
  always_ff @(posedge clk) begin
    if (rst) begin
      app_addr     <= '0;
      app_cmd      <= '0;
      app_en       <= 1'b0;
      app_wdf_data <= '0;
      app_wdf_mask <= '0;
      app_wdf_wren <= 1'b0;
      app_wdf_end  <= 1'b0;
      rr_ptr       <= 1'b0;
      burst_cnt    <= '0;
    end else if (grant_c) begin
      app_addr     <= sel_cmd.addr;
      app_cmd      <= sel_cmd.we ? CMD_WRITE : CMD_READ;
      app_en       <= 1'b1;
      app_wdf_data <= sel_cmd.wdata;
      app_wdf_mask <= sel_cmd.wmask;
      app_wdf_wren <= sel_cmd.we;
      app_wdf_end  <= sel_cmd.we;
      if (gport_c == rr_ptr) begin
        if (!burst_max) burst_cnt <= burst_cnt + BURST_W'(1);
      end else begin
        burst_cnt <= BURST_W'(1);
        rr_ptr    <= gport_c;
      end
    end else begin
      if (app_en && app_rdy) app_en <= 1'b0;
      if (app_wdf_wren && app_wdf_rdy) begin
        app_wdf_wren <= 1'b0;
        app_wdf_end  <= 1'b0;
      end
    end
  end

  // In-order read tag FIFO holding the issuing port id.
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_mem <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push_c) begin
        fifo_mem[wr_ptr] <= app_cmd == CMD_READ && rr_ptr_tag();
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop_c) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_c, pop_c})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Port id of the command currently in flight.
  logic issue_port;
  always_ff @(posedge clk) begin
    if (rst)          issue_port <= 1'b0;
    else if (grant_c) issue_port <= gport_c;
  end

  function automatic logic rr_ptr_tag();
    return issue_port;
  endfunction

  // Read return, registered one cycle after the MIG beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data      <= '0;
      p0_rd_valid  <= 1'b0;
      p1_rd_valid  <= 1'b0;
      err_unexp_rd <= 1'b0;
    end else begin
      p0_rd_valid <= app_rd_data_valid && !fifo_empty && !fifo_head;
      p1_rd_valid <= app_rd_data_valid && !fifo_empty && fifo_head;
      if (app_rd_data_valid && !fifo_empty) rd_data <= app_rd_data;
      if (app_rd_data_valid && fifo_empty)  err_unexp_rd <= 1'b1;
    end
  end

endmodule
